// File: rtl/bsg_link_arb_pkg.sv
// Shared types and width helpers for the bsg_link upstream arbiter.
package bsg_link_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/bsg_link_rr_picker.sv
// Combinational rotate-priority picker: first valid index at or after rr_ptr_i.
module bsg_link_rr_picker
    import bsg_link_arb_pkg::*;
#(
    parameter int NUM_REQ_P = 4,
    localparam int PTR_W = ptr_width(NUM_REQ_P)
) (
    input  logic [NUM_REQ_P-1:0] valid_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [NUM_REQ_P-1:0] grant_o,
    output logic [PTR_W-1:0]     sel_o,
    output logic                 found_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        sel_o   = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ_P; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQ_P;
            if (!found_o && valid_i[idx]) begin
                found_o      = 1'b1;
                grant_o[idx] = 1'b1;
                sel_o        = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_link_upstream_arbiter.sv
// Packet-granular round-robin arbiter feeding one bsg_link_ddr_upstream core port.
// Define BSG_LINK_ARB_CREDIT_EN to gate issue on a token-fed credit counter.
module bsg_link_upstream_arbiter
    import bsg_link_arb_pkg::*;
#(
    parameter int NUM_REQ_P     = 4,
    parameter int WIDTH_P       = 64,
    parameter int CREDITS_P     = 16,
    parameter int TOKEN_DECIM_P = 4,
    localparam int PTR_W  = ptr_width(NUM_REQ_P),
    localparam int CRED_W = credit_width(CREDITS_P)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ_P-1:0]         req_valid_i,
    input  logic [NUM_REQ_P*WIDTH_P-1:0] req_data_i,
    input  logic [NUM_REQ_P-1:0]         req_last_i,
    output logic [NUM_REQ_P-1:0]         req_ready_o,
    output logic                         link_valid_o,
    output logic [WIDTH_P-1:0]           link_data_o,
    input  logic                         link_ready_i,
    input  logic                         token_i,
    output logic [NUM_REQ_P-1:0]         grant_o,
    output logic                         busy_o,
    output logic [CRED_W-1:0]            credit_o,
    output logic                         credit_err_o
);

    arb_state_e             state_r, state_n;
    logic [NUM_REQ_P-1:0]   grant_r, grant_n;
    logic [PTR_W-1:0]       owner_r, owner_n;
    logic [PTR_W-1:0]       rr_ptr_r, rr_ptr_n;
    logic [NUM_REQ_P-1:0]   pick_grant;
    logic [PTR_W-1:0]       pick_sel;
    logic                   pick_found;
    logic                   locked;
    logic                   can_issue;
    logic                   accept;

    bsg_link_rr_picker #(.NUM_REQ_P(NUM_REQ_P)) picker (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_r),
        .grant_o  (pick_grant),
        .sel_o    (pick_sel),
        .found_o  (pick_found)
    );

    // Valid is built only from the owner's valid and credits, never from link_ready_i.
    assign locked       = (state_r == ARB_LOCKED);
    assign link_valid_o = locked & req_valid_i[owner_r] & can_issue;
    assign accept       = link_valid_o & link_ready_i;
    assign link_data_o  = locked ? req_data_i[int'(owner_r)*WIDTH_P +: WIDTH_P] : '0;
    assign req_ready_o  = accept ? grant_r : '0;
    assign grant_o      = grant_r;
    assign busy_o       = locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            grant_r  <= '0;
            owner_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            owner_r  <= owner_n;
            rr_ptr_r <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state_r;
        grant_n  = grant_r;
        owner_n  = owner_r;
        rr_ptr_n = rr_ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_n = ARB_LOCKED;
                    grant_n = pick_grant;
                    owner_n = pick_sel;
                end
            end
            ARB_LOCKED: begin
                if (accept && req_last_i[owner_r]) begin
                    state_n  = ARB_IDLE;
                    grant_n  = '0;
                    rr_ptr_n = (owner_r == PTR_W'(NUM_REQ_P - 1)) ? '0 : owner_r + 1'b1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
                grant_n = '0;
            end
        endcase
    end

`ifdef BSG_LINK_ARB_CREDIT_EN
    logic [CRED_W-1:0] credits_r;
    logic              credit_err_r;
    logic [CRED_W:0]   credit_sum;

    // One extra bit lets a token return overshoot the ceiling before clamping.
    assign credit_sum = {1'b0, credits_r} - (CRED_W+1)'(accept)
                      + (token_i ? (CRED_W+1)'(TOKEN_DECIM_P) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r    <= CRED_W'(CREDITS_P);
            credit_err_r <= 1'b0;
        end else if (credit_sum > (CRED_W+1)'(CREDITS_P)) begin
            credits_r    <= CRED_W'(CREDITS_P);
            credit_err_r <= 1'b1;
        end else begin
            credits_r    <= credit_sum[CRED_W-1:0];
        end
    end

    assign can_issue    = (credits_r != '0);
    assign credit_o     = credits_r;
    assign credit_err_o = credit_err_r;
`else
    logic unused_token;

    assign unused_token = token_i;
    assign can_issue    = 1'b1;
    assign credit_o     = '0;
    assign credit_err_o = 1'b0;
`endif

endmodule
